// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage and its load-alignment helper.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'd0,
    RESULT_MEM = 2'd1,
    RESULT_PC  = 2'd2,
    RESULT_IMM = 2'd3
  } result_mux_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Halfword loads need an even address; everything else except byte loads
  // is handled as a word access and needs word alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    if (funct3 == F3_LH || funct3 == F3_LHU) return offset[0];
    if (funct3 == F3_LB || funct3 == F3_LBU) return 1'b0;
    return offset != 2'b00;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: picks the byte/half/word at the given offset
// from a raw aligned memory word and sign- or zero-extends it.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: accepts one retiring instruction per cycle,
// waits for load data when needed, and drives the register-file write port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  result_mux_t           in_result_sel,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc4,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [2:0]            in_funct3,
  input  logic                  flush,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  misalign_err,
  output logic                  busy
);

  wb_state_t             r_state;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic [2:0]            r_funct3;
  logic [1:0]            r_offset;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;
  logic                  r_misalign_err;

  logic                  w_accept;
  logic [XLEN-1:0]       w_sel_result;
  logic [XLEN-1:0]       w_load_data;

  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state == WAIT_MEM);
  assign w_accept = in_valid & in_ready & ~flush;

  always_comb begin
    w_sel_result = in_alu_result;
    case (in_result_sel)
      RESULT_PC:  w_sel_result = in_pc4;
      RESULT_IMM: w_sel_result = in_imm;
      default:    w_sel_result = in_alu_result;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_word   (mem_rsp_data),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_misalign_err <= 1'b0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_funct3       <= F3_LW;
      r_offset       <= 2'b00;
    end else begin
      r_rf_we        <= 1'b0;
      r_misalign_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && in_result_sel != RESULT_MEM) begin
            r_rf_we    <= in_reg_write && (in_rd != '0);
            r_rf_waddr <= in_rd;
            r_rf_wdata <= w_sel_result;
          end else if (w_accept) begin
            r_rd        <= in_rd;
            r_reg_write <= in_reg_write;
            r_funct3    <= in_funct3;
            r_offset    <= in_alu_result[1:0];
            if (is_misaligned(in_funct3, in_alu_result[1:0])) r_misalign_err <= 1'b1;
            else                                              r_state        <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          // Flush is deliberately ignored here: an outstanding load always commits.
          if (mem_rsp_valid) begin
            r_rf_we    <= r_reg_write && (r_rd != '0);
            r_rf_waddr <= r_rd;
            r_rf_wdata <= w_load_data;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  result_mux_t in_result_sel;
  logic [31:0] in_alu_result, in_pc4, in_imm;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [2:0]  in_funct3;
  logic        flush;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  wb_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result_sel (in_result_sel),
    .in_alu_result (in_alu_result),
    .in_pc4        (in_pc4),
    .in_imm        (in_imm),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_funct3     (in_funct3),
    .flush         (flush),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .misalign_err  (misalign_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extraction from the load rules using shifts and masks.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] o,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'h0000_00FF;
    h = (w >> (16 * o[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [1:0] o);
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return o % 2 != 0;
    return o != 0;
  endfunction

  // Transaction-level model: at most one load outstanding, described by a pending record.
  bit          have_exp = 0;
  bit          pend = 0;
  logic [4:0]  pend_rd;
  bit          pend_rw;
  logic [2:0]  pend_f3;
  logic [1:0]  pend_off;
  bit          e_we, e_mis, e_rst;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  always @(negedge clk) begin
    if (have_exp) begin
      check("in_ready", 32'(in_ready), 32'(!pend));
      check("busy", 32'(busy), 32'(pend));
      check("rf_we", 32'(rf_we), 32'(e_we));
      check("misalign_err", 32'(misalign_err), 32'(e_mis));
      if (e_we || e_rst) begin
        check("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
        check("rf_wdata", rf_wdata, e_wdata);
      end
    end
    e_we = 0; e_mis = 0; e_rst = 0;
    if (reset) begin
      pend = 0; e_rst = 1; e_waddr = '0; e_wdata = '0;
      have_exp = 1;
    end else if (pend) begin
      if (mem_rsp_valid) begin
        e_we    = pend_rw && pend_rd != 0;
        e_waddr = pend_rd;
        e_wdata = ref_load(mem_rsp_data, pend_off, pend_f3);
        pend    = 0;
      end
    end else if (in_valid && !flush) begin
      if (in_result_sel == RESULT_MEM) begin
        if (ref_misaligned(in_funct3, in_alu_result[1:0])) e_mis = 1;
        else begin
          pend = 1; pend_rd = in_rd; pend_rw = in_reg_write;
          pend_f3 = in_funct3; pend_off = in_alu_result[1:0];
        end
      end else begin
        e_we    = in_reg_write && in_rd != 0;
        e_waddr = in_rd;
        e_wdata = (in_result_sel == RESULT_PC)  ? in_pc4 :
                  (in_result_sel == RESULT_IMM) ? in_imm : in_alu_result;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; flush = 0; mem_rsp_valid = 0;
  endtask

  task automatic offer(input result_mux_t sel, input logic [31:0] alu, input logic [4:0] rd,
                       input bit rw, input logic [2:0] f3);
    in_valid = 1; in_result_sel = sel; in_alu_result = alu;
    in_rd = rd; in_reg_write = rw; in_funct3 = f3;
  endtask

  task automatic load_and_respond(input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] word, input logic [4:0] rd, input bit rw,
                                  input logic [31:0] exp_data, input string name);
    offer(RESULT_MEM, addr, rd, rw, f3);
    step();
    quiet();
    check({name, "_ready_wait"}, 32'(in_ready), 32'd0);
    check({name, "_mis"}, 32'(misalign_err), 32'd0);
    mem_rsp_valid = 1; mem_rsp_data = word;
    step();
    mem_rsp_valid = 0;
    check({name, "_we"}, 32'(rf_we), 32'(rw && rd != 0));
    if (rw && rd != 0) check({name, "_wdata"}, rf_wdata, exp_data);
    check({name, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b011, 3'b111};
    reset = 1; quiet();
    in_result_sel = RESULT_ALU; in_alu_result = 0; in_pc4 = 0; in_imm = 0;
    in_rd = 0; in_reg_write = 0; in_funct3 = 0; mem_rsp_data = 0;
    step(); step();
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    reset = 0;

    // Single ALU op
    offer(RESULT_ALU, 32'h0000_1234, 5'd5, 1, 3'b000);
    step();
    check("alu_we", 32'(rf_we), 32'd1);
    check("alu_waddr", 32'(rf_waddr), 32'd5);
    check("alu_wdata", rf_wdata, 32'h0000_1234);

    // Back-to-back ALU, PC, IMM
    offer(RESULT_ALU, 32'h0000_0011, 5'd1, 1, 3'b000);
    step();
    check("b2b0_wdata", rf_wdata, 32'h0000_0011);
    check("b2b0_ready", 32'(in_ready), 32'd1);
    in_pc4 = 32'h0000_0104; offer(RESULT_PC, 32'hDEAD_BEEF, 5'd2, 1, 3'b000);
    step();
    check("b2b1_we", 32'(rf_we), 32'd1);
    check("b2b1_wdata", rf_wdata, 32'h0000_0104);
    in_imm = 32'hABCD_E000; offer(RESULT_IMM, 32'hDEAD_BEEF, 5'd3, 1, 3'b000);
    step();
    check("b2b2_we", 32'(rf_we), 32'd1);
    check("b2b2_wdata", rf_wdata, 32'hABCD_E000);
    check("b2b2_ready", 32'(in_ready), 32'd1);
    quiet();

    // LB at 0x3, response 4 cycles after acceptance
    offer(RESULT_MEM, 32'h0000_0003, 5'd7, 1, F3_LB);
    step();
    quiet();
    for (int i = 0; i < 3; i++) begin
      check("lb_ready_wait", 32'(in_ready), 32'd0);
      step();
    end
    check("lb_ready_wait", 32'(in_ready), 32'd0);
    mem_rsp_valid = 1; mem_rsp_data = 32'h80FF_0000;
    step();
    mem_rsp_valid = 0;
    check("lb_we", 32'(rf_we), 32'd1);
    check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    check("lb_ready_after", 32'(in_ready), 32'd1);

    load_and_respond(F3_LBU, 32'h3, 32'h80FF_0000, 5'd8, 1, 32'h0000_0080, "lbu");
    load_and_respond(F3_LH, 32'h2, 32'h80FF_0000, 5'd9, 1, 32'hFFFF_80FF, "lh");

    // Misaligned LW
    offer(RESULT_MEM, 32'h0000_0002, 5'd10, 1, F3_LW);
    step();
    quiet();
    check("lw_mis", 32'(misalign_err), 32'd1);
    check("lw_mis_we", 32'(rf_we), 32'd0);
    check("lw_mis_busy", 32'(busy), 32'd0);
    step();
    check("lw_mis_pulse", 32'(misalign_err), 32'd0);

    // rd=0 and reg_write=0 suppress writes
    offer(RESULT_ALU, 32'h55, 5'd0, 1, 3'b000);
    step();
    check("rd0_alu_we", 32'(rf_we), 32'd0);
    offer(RESULT_ALU, 32'h55, 5'd4, 0, 3'b000);
    step();
    check("rw0_alu_we", 32'(rf_we), 32'd0);
    load_and_respond(F3_LW, 32'h4, 32'h1234_5678, 5'd0, 1, 32'h1234_5678, "rd0_ld");
    load_and_respond(F3_LW, 32'h4, 32'h1234_5678, 5'd6, 0, 32'h1234_5678, "rw0_ld");

    // Flush on the offer, flush during WAIT_MEM
    offer(RESULT_ALU, 32'h77, 5'd11, 1, 3'b000); flush = 1;
    step();
    check("flush_we", 32'(rf_we), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    flush = 0;
    offer(RESULT_MEM, 32'h8, 5'd12, 1, F3_LW);
    step();
    offer(RESULT_ALU, 32'h99, 5'd13, 1, 3'b000); flush = 1;
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
    step();
    quiet();
    check("flush_wait_we", 32'(rf_we), 32'd1);
    check("flush_wait_waddr", 32'(rf_waddr), 32'd12);
    check("flush_wait_wdata", rf_wdata, 32'hCAFE_F00D);

    // Response in IDLE is ignored
    mem_rsp_valid = 1;
    step();
    mem_rsp_valid = 0;
    check("idle_rsp_we", 32'(rf_we), 32'd0);
    check("idle_rsp_busy", 32'(busy), 32'd0);

    // Reset during WAIT_MEM drops the load
    offer(RESULT_MEM, 32'h0, 5'd14, 1, F3_LW);
    step();
    quiet();
    reset = 1;
    step();
    reset = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1111_2222;
    step();
    mem_rsp_valid = 0;
    check("rst_wait_we", 32'(rf_we), 32'd0);
    check("rst_wait_ready", 32'(in_ready), 32'd1);
    check("rst_wait_busy", 32'(busy), 32'd0);

    // Randomized traffic; the negedge model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      in_valid      = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 9) == 0);
      in_result_sel = result_mux_t'($urandom_range(0, 3));
      in_alu_result = $urandom;
      in_pc4        = $urandom;
      in_imm        = $urandom;
      in_rd         = 5'($urandom_range(0, 31));
      in_reg_write  = ($urandom_range(0, 7) != 0);
      in_funct3     = f3_tab[$urandom_range(0, 7)];
      if (in_funct3 == 3'b011 || in_funct3 == 3'b111) in_alu_result[1:0] = 2'b00;
      mem_rsp_valid = ($urandom_range(0, 9) < 4);
      mem_rsp_data  = $urandom;
      step();
    end
    reset = 0; quiet();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
